// File: rtl/addc_pipe_pkg.sv
// Shared ALU definitions for the pipelined add/subtract-with-carry unit:
// op-select encoding and flag-register bit positions.
package addc_pipe_pkg;

    localparam logic ALU_SUB = 1'b1;

    localparam int FLAG_C = 0;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 2;

    typedef struct packed {
        logic z;
        logic v;
        logic c;
    } alu_flags_t;

endpackage

// File: rtl/addc_pipe_if.sv
// Operand/result handshake bundle for addc_pipe; master drives operands and
// out_ready, slave (the adder) returns in_ready and the result beat.
interface addc_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, sub, cin, out_ready,
        input  in_ready, out_valid, s, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, sub, cin, out_ready,
        output in_ready, out_valid, s, cout, ovf, zero
    );
endinterface

// File: rtl/addc_chunk.sv
// Combinational CW-bit adder slice: sum, carry out, carry into the slice MSB
// (for signed overflow) and an all-zero indication of the slice sum.
module addc_chunk #(
    parameter int CW = 8
) (
    input  logic [CW-1:0] x,
    input  logic [CW-1:0] y,
    input  logic          ci,
    output logic [CW-1:0] sum,
    output logic          co,
    output logic          c_msb_in,
    output logic          is_zero
);
    logic [CW:0] full;

    assign full     = {1'b0, x} + {1'b0, y} + {{CW{1'b0}}, ci};
    assign sum      = full[CW-1:0];
    assign co       = full[CW];
    // With CW=1 this reduces to ci itself.
    assign c_msb_in = x[CW-1] ^ y[CW-1] ^ full[CW-1];
    assign is_zero  = ~|full[CW-1:0];
endmodule

// File: rtl/addc_pipe.sv
// Pipelined WIDTH-bit add/subtract-with-carry: one CW-bit chunk per stage,
// operands skewed forward, sum chunks deskewed, single global stall enable.
module addc_pipe
    import addc_pipe_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input logic        clk,
    input logic        rst,
    addc_pipe_if.slave bus
);
    localparam int CW = WIDTH / STAGES;

    logic en;

    logic [STAGES-1:0]            vld_q;
    logic [STAGES-1:0][WIDTH-1:0] a_q;
    logic [STAGES-1:0][WIDTH-1:0] b_q;
    logic [STAGES-1:0][WIDTH-1:0] s_q;
    logic [STAGES-1:0]            c_q;
    logic [STAGES-1:0]            z_q;
    logic                         ovf_q;

    logic [STAGES-1:0]            vld_d;
    logic [STAGES-1:0][WIDTH-1:0] a_d;
    logic [STAGES-1:0][WIDTH-1:0] b_d;
    logic [STAGES-1:0][WIDTH-1:0] s_in;
    logic [STAGES-1:0][WIDTH-1:0] s_d;
    logic [STAGES-1:0]            c_in;
    logic [STAGES-1:0]            z_in;
    logic [STAGES-1:0]            z_d;
    logic                         ovf_d;

    logic [STAGES-1:0][CW-1:0]    ch_sum;
    logic [STAGES-1:0]            ch_co;
    logic [STAGES-1:0]            ch_cmsb;
    logic [STAGES-1:0]            ch_z;

    logic unused_bits;

    assign en = !vld_q[STAGES-1] || bus.out_ready;

    // Stage inputs: stage 0 takes the bus, stage k takes stage k-1 registers.
    always_comb begin
        vld_d[0] = bus.in_valid;
        a_d[0]   = bus.a;
        b_d[0]   = (bus.sub == ALU_SUB) ? ~bus.b : bus.b;
        s_in[0]  = '0;
        c_in[0]  = bus.cin;
        z_in[0]  = 1'b1;
        for (int k = 1; k < STAGES; k++) begin
            vld_d[k] = vld_q[k-1];
            a_d[k]   = a_q[k-1];
            b_d[k]   = b_q[k-1];
            s_in[k]  = s_q[k-1];
            c_in[k]  = c_q[k-1];
            z_in[k]  = z_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_chunk
        addc_chunk #(
            .CW(CW)
        ) u_chunk (
            .x        (a_d[k][k*CW +: CW]),
            .y        (b_d[k][k*CW +: CW]),
            .ci       (c_in[k]),
            .sum      (ch_sum[k]),
            .co       (ch_co[k]),
            .c_msb_in (ch_cmsb[k]),
            .is_zero  (ch_z[k])
        );
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            s_d[k]             = s_in[k];
            s_d[k][k*CW +: CW] = ch_sum[k];
            z_d[k]             = z_in[k] & ch_z[k];
        end
        ovf_d = ch_cmsb[STAGES-1] ^ ch_co[STAGES-1];
    end

    // Stage registers: all advance together on en, bubbles included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            c_q   <= '0;
            z_q   <= '0;
            ovf_q <= 1'b0;
        end else if (en) begin
            vld_q <= vld_d;
            a_q   <= a_d;
            b_q   <= b_d;
            s_q   <= s_d;
            c_q   <= ch_co;
            z_q   <= z_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.in_ready  = en;
    assign bus.out_valid = vld_q[STAGES-1];
    assign bus.s         = s_q[STAGES-1];
    assign bus.cout      = c_q[STAGES-1];
    assign bus.ovf       = ovf_q;
    assign bus.zero      = z_q[STAGES-1];

    // Last-stage operand copies and lower-chunk MSB carries have no reader.
    assign unused_bits = ^{a_q[STAGES-1], b_q[STAGES-1], ch_cmsb};
endmodule

// File: tb/tb_addc_pipe.sv
// Bench for addc_pipe: 32/4 instance with table vectors, backpressure and
// reset-in-flight sequences; 8/1 and 8/8 instances for latency and flags.
module tb_addc_pipe;

    logic clk;
    logic rst;
    int   cyc;
    int   total;
    int   bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    addc_pipe_if #(.WIDTH(32)) bus32 ();
    addc_pipe_if #(.WIDTH(8))  bus8a ();
    addc_pipe_if #(.WIDTH(8))  bus8b ();

    addc_pipe #(.WIDTH(32), .STAGES(4)) u32 (.clk(clk), .rst(rst), .bus(bus32));
    addc_pipe #(.WIDTH(8),  .STAGES(1)) u8a (.clk(clk), .rst(rst), .bus(bus8a));
    addc_pipe #(.WIDTH(8),  .STAGES(8)) u8b (.clk(clk), .rst(rst), .bus(bus8b));

    logic [7:0] v8_a, v8_b;
    logic       v8_sub, v8_cin, v8_valid;

    assign bus8a.in_valid  = v8_valid;
    assign bus8a.a         = v8_a;
    assign bus8a.b         = v8_b;
    assign bus8a.sub       = v8_sub;
    assign bus8a.cin       = v8_cin;
    assign bus8a.out_ready = 1'b1;
    assign bus8b.in_valid  = v8_valid;
    assign bus8b.a         = v8_a;
    assign bus8b.b         = v8_b;
    assign bus8b.sub       = v8_sub;
    assign bus8b.cin       = v8_cin;
    assign bus8b.out_ready = 1'b1;

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        v;
        logic        z;
        int          acc;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        cin;
        logic [31:0] s;
        logic        c;
        logic        v;
        logic        z;
    } vec32_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic       cin;
        logic [7:0] s;
        logic       c;
        logic       v;
        logic       z;
    } vec8_t;

    exp_t       q[$];
    exp_t       e_mon;
    int         popped;
    int         expect_pops;
    bit         chk_lat;
    bit         prev_stall;
    logic [35:0] snap;
    logic [3:0] pat;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Result monitor and stall checker, sampling mid-cycle.
    initial begin
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall)
                    chk("stall_hold", {bus32.out_valid, bus32.s, bus32.cout, bus32.ovf, bus32.zero}, snap);
                if (bus32.out_valid && !bus32.out_ready) begin
                    chk("stall_in_ready", bus32.in_ready, 0);
                    prev_stall = 1'b1;
                    snap = {bus32.out_valid, bus32.s, bus32.cout, bus32.ovf, bus32.zero};
                end else begin
                    prev_stall = 1'b0;
                end
                if (bus32.out_valid && bus32.out_ready) begin
                    chk("beat_expected", q.size() > 0, 1);
                    if (q.size() > 0) begin
                        e_mon = q.pop_front();
                        popped++;
                        chk("result", {bus32.s, bus32.cout, bus32.ovf, bus32.zero},
                            {e_mon.s, e_mon.c, e_mon.v, e_mon.z});
                        if (chk_lat) chk("latency", cyc - e_mon.acc, 3);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk(input logic [31:0] s, input logic c, input logic v, input logic z);
        exp_t m;
        m.s = s; m.c = c; m.v = v; m.z = z; m.acc = 0;
        return m;
    endfunction

    // Called at posedge+1; returns after the accepting edge (+1).
    task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic sub,
                          input logic cin, input exp_t e, output int acc);
        bit accepted;
        int g;
        accepted = 1'b0;
        g = 0;
        bus32.a = a; bus32.b = b; bus32.sub = sub; bus32.cin = cin;
        bus32.in_valid = 1'b1;
        while (!accepted && g < 50) begin
            @(negedge clk);
            accepted = bus32.in_ready;
            @(posedge clk);
            #1;
            g++;
        end
        bus32.in_valid = 1'b0;
        chk("accept", accepted, 1);
        acc = cyc;
        if (accepted) begin
            e.acc = cyc;
            q.push_back(e);
            expect_pops++;
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (q.size() != 0 && g < 200) begin
            @(posedge clk);
            g++;
        end
        @(posedge clk);
        #1;
        chk("drain", q.size(), 0);
    endtask

    task automatic run8(input vec8_t v);
        int t0;
        bit seen_a, seen_b;
        seen_a = 1'b0;
        seen_b = 1'b0;
        v8_a = v.a; v8_b = v.b; v8_sub = v.sub; v8_cin = v.cin;
        v8_valid = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        v8_valid = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (!seen_a && bus8a.out_valid) begin
                seen_a = 1'b1;
                chk("w8s1_latency", cyc - t0, 0);
                chk("w8s1_result", {bus8a.s, bus8a.cout, bus8a.ovf, bus8a.zero}, {v.s, v.c, v.v, v.z});
            end
            if (!seen_b && bus8b.out_valid) begin
                seen_b = 1'b1;
                chk("w8s8_latency", cyc - t0, 7);
                chk("w8s8_result", {bus8b.s, bus8b.cout, bus8b.ovf, bus8b.zero}, {v.s, v.c, v.v, v.z});
            end
        end
        chk("w8s1_seen", seen_a, 1);
        chk("w8s8_seen", seen_b, 1);
        @(posedge clk);
        #1;
    endtask

    vec32_t tbl[10];
    vec8_t  tbl8[6];
    int     acc;
    int     rel;
    int     base;

    initial begin
        total = 0; bad = 0; popped = 0; expect_pops = 0;
        chk_lat = 1'b1;
        pat = 4'b1001;
        tbl[0] = '{32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        tbl[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{32'h0FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h10000000, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{32'h80000000, 32'h00000001, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{32'h00000005, 32'h00000005, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{32'h12345678, 32'h12345678, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
        tbl[8] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
        tbl[9] = '{32'h00FF00FF, 32'h0000FF01, 1'b0, 1'b1, 32'h01000001, 1'b0, 1'b0, 1'b0};
        tbl8[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        tbl8[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
        tbl8[2] = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0};
        tbl8[3] = '{8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0};
        tbl8[4] = '{8'h05, 8'h05, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};
        tbl8[5] = '{8'h00, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};

        bus32.in_valid = 1'b0; bus32.a = '0; bus32.b = '0; bus32.sub = 1'b0; bus32.cin = 1'b0;
        bus32.out_ready = 1'b1;
        v8_valid = 1'b0; v8_a = '0; v8_b = '0; v8_sub = 1'b0; v8_cin = 1'b0;
        rst = 1'b1;
        #3;
        chk("reset_outputs", {bus32.out_valid, bus32.s, bus32.cout, bus32.ovf, bus32.zero}, 0);
        chk("reset_in_ready", bus32.in_ready, 1);
        chk("reset_w8s8_valid", bus8b.out_valid, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Table vectors, back-to-back with no backpressure.
        for (int i = 0; i < 10; i++)
            send32(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].cin,
                   mk(tbl[i].s, tbl[i].c, tbl[i].v, tbl[i].z), acc);
        drain();

        // Backpressure: out_ready 1,0,0,1 repeating.
        chk_lat = 1'b0;
        base = popped;
        fork
            begin
                for (int i = 1; i <= 8; i++)
                    send32(32'(i), 32'(2 * i), 1'b0, 1'b0, mk(32'(3 * i), 1'b0, 1'b0, 1'b0), acc);
            end
            begin
                for (int n = 0; n < 100 && popped < base + 8; n++) begin
                    bus32.out_ready = pat[n % 4];
                    @(posedge clk);
                    #1;
                end
                bus32.out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_count", popped - base, 8);

        // Reset with three beats in flight.
        chk_lat = 1'b1;
        send32(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, mk(32'h80000000, 1'b0, 1'b1, 1'b0), acc);
        send32(32'h00000010, 32'h00000020, 1'b0, 1'b0, mk(32'h00000030, 1'b0, 1'b0, 1'b0), acc);
        send32(32'h00000100, 32'h00000001, 1'b1, 1'b1, mk(32'h000000FF, 1'b1, 1'b0, 1'b0), acc);
        @(posedge clk);
        #1;
        chk("pre_rst_valid", bus32.out_valid, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_async_outputs", {bus32.out_valid, bus32.s, bus32.cout, bus32.ovf, bus32.zero}, 0);
        expect_pops -= q.size();
        q.delete();
        #1;
        rst = 1'b0;
        rel = cyc;
        send32(32'hCAFE0000, 32'h0000BABE, 1'b0, 1'b0, mk(32'hCAFEBABE, 1'b0, 1'b0, 1'b0), acc);
        chk("first_accept_after_rst", acc - rel, 1);
        drain();

        // Parameter sweep on the 8-bit instances.
        for (int i = 0; i < 6; i++) run8(tbl8[i]);

        repeat (10) @(posedge clk);
        #1;
        chk("queue_empty", q.size(), 0);
        chk("beat_count", popped, expect_pops);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/addc_pipe.md
Name: addc_pipe

Overview:
- Parametrised, pipelined add/subtract-with-carry unit. It is the next generation of the team's 32-bit combinational carry adder.
- Splits a WIDTH-bit add into STAGES carry-chained chunks, one chunk per clock, so wide adds close timing at the CPU clock.
- Produces carry, signed-overflow and zero flags.
- Sits between the ALU operand latches and the writeback/flags register, and uses a valid/ready handshake.

Parameters:
- WIDTH, 32: operand and result width in bits; must be at least 2.
- STAGES, 4: pipeline depth, i.e. the number of chunks. WIDTH % STAGES must be 0, and chunk width CW = WIDTH/STAGES must be at least 1.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: reset, asynchronous and active-high.
- in_valid, input, 1: operand beat is valid.
- in_ready, output, 1: unit accepts a beat this cycle.
- a, input, WIDTH: operand A.
- b, input, WIDTH: operand B.
- sub, input, 1: 0 = add, 1 = subtract (B is inverted).
- cin, input, 1: carry-in.
- out_valid, output, 1: result beat is valid.
- out_ready, input, 1: downstream accepts the result.
- s, output, WIDTH: sum.
- cout, output, 1: carry out of bit WIDTH-1.
- ovf, output, 1: two's-complement overflow.
- zero, output, 1: s == 0.

Behaviour:
- Arithmetic:
  - B' = sub ? ~b : b.
  - {cout, s} = a + B' + cin, computed modulo 2^(WIDTH+1).
  - With sub=1, cin=1 gives a-b and cin=0 gives a-b-1 (SBC).
  - With sub=1, cout=1 means no borrow.
  - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - zero = (s == 0). It is accumulated per chunk: each chunk ANDs its own all-zero term into a zero bit carried forward.
- Pipeline structure:
  - Stage k (0..STAGES-1) adds operand chunk k with the carry registered from stage k-1; stage 0 uses cin.
  - Operand chunks above k travel forward in skew registers.
  - Completed sum chunks travel forward in deskew registers.
  - Each stage holds a valid bit.
- Stall control:
  - Global enable en = !out_valid || out_ready.
  - All stage registers advance only when en=1.
  - in_ready = en, driven combinationally.
  - A beat is accepted when in_valid && in_ready.
  - Bubbles are not compressed; an invalid stage advances like a valid one.
- Latency and throughput:
  - A beat accepted at edge t appears with out_valid=1 after edge t+STAGES-1. Latency is STAGES cycles from acceptance with no stall.
  - STAGES=1 gives a single registered output, latency 1.
  - Throughput is 1 beat per cycle while out_ready=1.
- Stall hold:
  - While out_valid && !out_ready, s, cout, ovf and zero are held stable, and no internal stage changes.
  - in_ready=0 during the stall.
- Ordering: results emerge strictly in acceptance order, with no loss or duplication.
- Reset:
  - Asynchronous assertion clears every valid bit, carry, skew and deskew register.
  - Outputs go to out_valid=0, s=0, cout=0, ovf=0, zero=0 immediately.
  - In-flight beats are dropped, and none emerge after rst deasserts.
  - First acceptance is possible in the first cycle after deassertion.
- Invalid-beat data: a, b, sub and cin are don't-care when in_valid=0. Outputs are don't-care but stable when out_valid=0; registers load whatever was present.
- Boundary cases:
  - Full carry ripple across all chunk boundaries must be exact, e.g. 0xFFFFFFFF+1.
  - The overflow carry-into-MSB is taken inside the top chunk. When CW=1 it equals the incoming registered carry.

Decomposition:
- Shared ALU definitions package/header (alu_defs) holds:
  - the op-select encoding constant (ALU_SUB=1'b1);
  - the flag bit positions for the flags register (C, V, Z).
- One natural sub-module: addc_chunk. It is a combinational CW-bit adder with inputs (x, y, ci) and outputs (sum, co, c_msb_in, is_zero).
- addc_pipe instantiates STAGES copies of addc_chunk using a generate loop.
- Registers, skew/deskew logic and stall logic stay in addc_pipe.

Test Plan:
All scenarios use WIDTH=32, STAGES=4 unless noted.
1. Add with wrap: a=0x00000001, b=0xFFFFFFFF, sub=0, cin=0, accepted at edge t → out_valid after edge t+3 with s=0, cout=1, ovf=0, zero=1.
2. Signed overflow and chunk ripple:
   - a=0x7FFFFFFF, b=1, add → s=0x80000000, cout=0, ovf=1, zero=0.
   - a=0x0FFFFFFF, b=1 → s=0x10000000, cout=0, ovf=0.
3. Subtract:
   - sub=1, cin=1, a=5, b=7 → s=0xFFFFFFFE, cout=0, ovf=0.
   - a=0x80000000, b=1 → s=0x7FFFFFFF, cout=1, ovf=1.
   - sub=1, cin=0, a=5, b=5 → s=0xFFFFFFFF, cout=0.
4. Backpressure: 8 back-to-back beats with operands i and 2i, and out_ready toggled 1,0,0,1,… → 8 results 3i in order; s is stable during every stall; in_ready=0 on every stall cycle; no extra beats.
5. Reset mid-flight: 3 beats accepted, then rst pulsed asynchronously between edges → out_valid=0 and flags=0 immediately. No result appears after release. A new beat accepted next cycle emerges with latency 4.
6. Parameter sweep: repeat scenarios 1 and 3 with (WIDTH=8, STAGES=1) and (WIDTH=8, STAGES=8) → latency 1 and 8 respectively. 0xFF+0x01 gives s=0x00, cout=1, zero=1; 0x7F+0x01 gives ovf=1.
